multi_stream_result_reducer: RTL and testbench

Parametrised collector for the per-permutation pipeline results of one full permutation pipeline. It buffers the in-order result streams of `NUM_STREAMS` aggregating pipelines in per-stream FIFOs. When every enabled stream has a result, it pops one entry from each in lockstep and reduces them through a registered adder tree to a single `pcoeffSum`/`pcoeffCount` pair. It generalises the fixed 30-stream collector with these additions: arbitrary stream count and widths, a runtime stream mask, per-stream almost-full backpressure, and sticky overflow detection.

---
 rtl/multi_stream_result_reducer.sv | 160 ++++++++++++++++
 tb/tb_multi_stream_result_reducer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_stream_result_reducer.sv
// Buffers NUM_STREAMS in-order result streams in per-stream FIFOs, pops them in
// lockstep and reduces one entry per stream to a single pcoeffSum/pcoeffCount pair.
module multi_stream_result_reducer #(
    parameter int NUM_STREAMS        = 30,
    parameter int SUM_WIDTH          = 43,
    parameter int COUNT_WIDTH        = 8,
    parameter int DEPTH_LOG2         = 9,
    parameter int ALMOST_FULL_MARGIN = 16,
    parameter int READ_LATENCY       = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NUM_STREAMS-1:0]                         streamEnable,
    input  logic [NUM_STREAMS-1:0]                         writes,
    input  logic [NUM_STREAMS*SUM_WIDTH-1:0]               sums,
    input  logic [NUM_STREAMS*COUNT_WIDTH-1:0]             counts,
    input  logic [NUM_STREAMS-1:0]                         eccIn,
    output logic [NUM_STREAMS-1:0]                         almostFull,
    input  logic                                           slowDown,
    output logic                                           resultValid,
    output logic [SUM_WIDTH+$clog2(NUM_STREAMS)-1:0]       pcoeffSum,
    output logic [COUNT_WIDTH+$clog2(NUM_STREAMS)-1:0]     pcoeffCount,
    output logic                                           allEmpty,
    output logic [NUM_STREAMS-1:0]                         overflow,
    output logic                                           eccStatus
);
    localparam int L       = $clog2(NUM_STREAMS);
    localparam int LATENCY = READ_LATENCY + L + 1;
    localparam int PW      = DEPTH_LOG2 + 1;
    localparam int FW      = DEPTH_LOG2 + 2;
    localparam int EW      = SUM_WIDTH + COUNT_WIDTH + 1;
    localparam int TSW     = SUM_WIDTH + L;
    localparam int TCW     = COUNT_WIDTH + L;
    localparam logic [FW-1:0] DEPTH = FW'(1) << DEPTH_LOG2;

    logic [PW-1:0]          rptr;
    logic [PW-1:0]          wptr        [NUM_STREAMS];
    logic [PW-1:0]          occupancy   [NUM_STREAMS];
    logic [FW-1:0]          freeEntries [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] full;
    logic [NUM_STREAMS-1:0] empty;
    logic [NUM_STREAMS-1:0] writeAccept;
    logic [NUM_STREAMS-1:0] parityError;
    logic [NUM_STREAMS*SUM_WIDTH-1:0]   leafSum;
    logic [NUM_STREAMS*COUNT_WIDTH-1:0] leafCount;
    logic [LATENCY-1:0]     validPipe;
    logic                   pop;

    assign pop      = !slowDown && (|streamEnable) && ((streamEnable & empty) == '0);
    assign allEmpty = (&empty) && (validPipe == '0);

    for (genvar g = 0; g < NUM_STREAMS; g++) begin : gen_stream
        logic [EW-1:0]          mem      [2**DEPTH_LOG2];
        logic [EW-1:0]          readPipe [READ_LATENCY];
        logic [SUM_WIDTH-1:0]   inSum;
        logic [COUNT_WIDTH-1:0] inCount;

        assign inSum          = sums[g*SUM_WIDTH +: SUM_WIDTH];
        assign inCount        = counts[g*COUNT_WIDTH +: COUNT_WIDTH];
        assign occupancy[g]   = wptr[g] - rptr;
        assign freeEntries[g] = DEPTH - FW'(occupancy[g]);
        assign full[g]        = occupancy[g][DEPTH_LOG2];
        assign empty[g]       = (occupancy[g] == '0);
        assign writeAccept[g] = writes[g] && streamEnable[g] && (!full[g] || pop);

        // Each entry carries an even-parity bit so corrupted memory contents show up as ECC errors.
        always_ff @(posedge clk) begin
            if (writeAccept[g])
                mem[wptr[g][DEPTH_LOG2-1:0]] <= {^{inSum, inCount}, inSum, inCount};
        end

        always_ff @(posedge clk) begin
            if (pop)
                readPipe[0] <= mem[rptr[DEPTH_LOG2-1:0]];
            for (int k = 1; k < READ_LATENCY; k++)
                readPipe[k] <= readPipe[k-1];
        end

        assign parityError[g] = validPipe[READ_LATENCY-1] && streamEnable[g]
                                && (^readPipe[READ_LATENCY-1]);
        assign leafSum[g*SUM_WIDTH +: SUM_WIDTH] =
            streamEnable[g] ? readPipe[READ_LATENCY-1][COUNT_WIDTH +: SUM_WIDTH] : '0;
        assign leafCount[g*COUNT_WIDTH +: COUNT_WIDTH] =
            streamEnable[g] ? readPipe[READ_LATENCY-1][COUNT_WIDTH-1:0] : '0;
    end

    // Disabled streams advance their write pointer with every pop so their occupancy stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr <= '0;
            for (int i = 0; i < NUM_STREAMS; i++)
                wptr[i] <= '0;
        end else begin
            if (pop)
                rptr <= rptr + PW'(1);
            for (int i = 0; i < NUM_STREAMS; i++)
                if (writeAccept[i] || (pop && !streamEnable[i]))
                    wptr[i] <= wptr[i] + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            validPipe  <= '0;
            almostFull <= '0;
            overflow   <= '0;
            eccStatus  <= 1'b0;
        end else begin
            validPipe <= {validPipe[LATENCY-2:0], pop};
            for (int i = 0; i < NUM_STREAMS; i++) begin
                almostFull[i] <= (freeEntries[i] <= FW'(ALMOST_FULL_MARGIN));
                if (writes[i] && streamEnable[i] && full[i] && !pop)
                    overflow[i] <= 1'b1;
            end
            if ((|eccIn) || (|parityError))
                eccStatus <= 1'b1;
        end
    end

    // Level 0 is the masked memory output; every later level is one register stage wide by one bit.
    for (genvar lv = 0; lv <= L; lv++) begin : gen_level
        localparam int NODES = (NUM_STREAMS + (1 << lv) - 1) >> lv;
        logic [TSW-1:0] nodeSum   [NODES];
        logic [TCW-1:0] nodeCount [NODES];

        for (genvar n = 0; n < NODES; n++) begin : gen_node
            if (lv == 0) begin : gen_leaf
                assign nodeSum[n]   = TSW'(leafSum[n*SUM_WIDTH +: SUM_WIDTH]);
                assign nodeCount[n] = TCW'(leafCount[n*COUNT_WIDTH +: COUNT_WIDTH]);
            end else begin : gen_inner
                localparam int PREV = (NUM_STREAMS + (1 << (lv - 1)) - 1) >> (lv - 1);
                if (2 * n + 1 < PREV) begin : gen_pair
                    always_ff @(posedge clk) begin
                        nodeSum[n]   <= gen_level[lv-1].nodeSum[2*n] + gen_level[lv-1].nodeSum[2*n+1];
                        nodeCount[n] <= gen_level[lv-1].nodeCount[2*n] + gen_level[lv-1].nodeCount[2*n+1];
                    end
                end else begin : gen_pass
                    always_ff @(posedge clk) begin
                        nodeSum[n]   <= gen_level[lv-1].nodeSum[2*n];
                        nodeCount[n] <= gen_level[lv-1].nodeCount[2*n];
                    end
                end
            end
        end
    end

    assign resultValid = validPipe[LATENCY-1];

    // The output register only loads when a real reduction reaches the tree root.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcoeffSum   <= '0;
            pcoeffCount <= '0;
        end else if (validPipe[LATENCY-2]) begin
            pcoeffSum   <= gen_level[L].nodeSum[0];
            pcoeffCount <= gen_level[L].nodeCount[0];
        end
    end

endmodule

// File: tb/tb_multi_stream_result_reducer.sv
// Self-checking bench for multi_stream_result_reducer: table vectors, corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_multi_stream_result_reducer;
    localparam int NS    = 30;
    localparam int SW    = 43;
    localparam int CW    = 8;
    localparam int DL2   = 9;
    localparam int AFM   = 16;
    localparam int RL    = 2;
    localparam int L     = $clog2(NS);
    localparam int LAT   = RL + L + 1;
    localparam int DEPTH = 1 << DL2;
    localparam int TSW   = SW + L;
    localparam int TCW   = CW + L;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     streamEnable, writes, eccIn, almostFull, overflow;
    logic [NS*SW-1:0]  sums;
    logic [NS*CW-1:0]  counts;
    logic              slowDown, resultValid, allEmpty, eccStatus;
    logic [TSW-1:0]    pcoeffSum;
    logic [TCW-1:0]    pcoeffCount;

    int nCompared   = 0;
    int nMismatched = 0;
    int cycle       = 0;
    int validSeen   = 0;
    int lastValidAt = 0;

    // Reference model: one queue of entries per stream plus a queue of scheduled results.
    logic [SW-1:0]  qSum [NS][$];
    logic [CW-1:0]  qCnt [NS][$];
    int             dueQ [$];
    logic [TSW-1:0] sumQ [$];
    logic [TCW-1:0] cntQ [$];
    logic [NS-1:0]  mAF, mOvf;
    logic           mEcc;

    typedef struct {
        logic [NS-1:0]  en;
        logic [NS-1:0]  wmask;
        logic [SW-1:0]  base;
        logic [CW-1:0]  cnt;
        logic [TSW-1:0] expSum;
        logic [TCW-1:0] expCnt;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    multi_stream_result_reducer #(
        .NUM_STREAMS(NS), .SUM_WIDTH(SW), .COUNT_WIDTH(CW), .DEPTH_LOG2(DL2),
        .ALMOST_FULL_MARGIN(AFM), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst(rst), .streamEnable(streamEnable), .writes(writes),
        .sums(sums), .counts(counts), .eccIn(eccIn), .almostFull(almostFull),
        .slowDown(slowDown), .resultValid(resultValid), .pcoeffSum(pcoeffSum),
        .pcoeffCount(pcoeffCount), .allEmpty(allEmpty), .overflow(overflow),
        .eccStatus(eccStatus)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, actual, expected);
        end
    endtask

    task automatic setStream(input int i, input logic [SW-1:0] s, input logic [CW-1:0] c);
        writes[i]         = 1'b1;
        sums[i*SW +: SW]  = s;
        counts[i*CW +: CW] = c;
    endtask

    // Advances one clock: steps the model on the current inputs, then compares every output.
    task automatic applyStimulus();
        logic           pop;
        logic [TSW-1:0] s;
        logic [TCW-1:0] c;
        logic [NS-1:0]  afNext;
        logic           expValid, expEmpty;
        pop = !slowDown && (streamEnable != '0);
        for (int i = 0; i < NS; i++) begin
            if (streamEnable[i] && qSum[i].size() == 0) pop = 1'b0;
            afNext[i] = (DEPTH - qSum[i].size()) <= AFM;
        end
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                qSum[i].delete();
                qCnt[i].delete();
            end
            dueQ.delete(); sumQ.delete(); cntQ.delete();
            mAF = '0; mOvf = '0; mEcc = 1'b0;
        end else begin
            if (pop) begin
                s = '0; c = '0;
                for (int i = 0; i < NS; i++)
                    if (streamEnable[i]) begin
                        s = s + TSW'(qSum[i].pop_front());
                        c = c + TCW'(qCnt[i].pop_front());
                    end
                dueQ.push_back(cycle + LAT); sumQ.push_back(s); cntQ.push_back(c);
            end
            for (int i = 0; i < NS; i++)
                if (writes[i] && streamEnable[i]) begin
                    if (qSum[i].size() < DEPTH) begin
                        qSum[i].push_back(sums[i*SW +: SW]);
                        qCnt[i].push_back(counts[i*CW +: CW]);
                    end else mOvf[i] = 1'b1;
                end
            if (eccIn != '0) mEcc = 1'b1;
            mAF = afNext;
        end
        @(posedge clk);
        #1;
        cycle++;
        expEmpty = (dueQ.size() == 0);
        for (int i = 0; i < NS; i++) if (qSum[i].size() != 0) expEmpty = 1'b0;
        expValid = (dueQ.size() > 0) && (dueQ[0] == cycle);
        checkOutput("resultValid", 64'(resultValid), 64'(expValid));
        if (expValid) begin
            checkOutput("pcoeffSum", 64'(pcoeffSum), 64'(sumQ[0]));
            checkOutput("pcoeffCount", 64'(pcoeffCount), 64'(cntQ[0]));
            void'(dueQ.pop_front()); void'(sumQ.pop_front()); void'(cntQ.pop_front());
        end
        checkOutput("almostFull", 64'(almostFull), 64'(mAF));
        checkOutput("overflow", 64'(overflow), 64'(mOvf));
        checkOutput("eccStatus", 64'(eccStatus), 64'(mEcc));
        checkOutput("allEmpty", 64'(allEmpty), 64'(expEmpty));
        if (resultValid) begin
            validSeen++;
            lastValidAt = cycle;
        end
    endtask

    initial begin
        int             start, seen0, firstAt, found;
        logic [63:0]    r;
        logic [TSW-1:0] gotSum;
        logic [TCW-1:0] gotCnt;

        vecs[0] = '{'1,             '1,        43'd1,   8'd1,   48'd465, 13'd30};
        vecs[1] = '{30'h1,          30'h7,     43'd100, 8'd5,   48'd100, 13'd5};
        vecs[2] = '{30'h5,          '1,        43'd10,  8'd2,   48'd22,  13'd4};
        vecs[3] = '{30'h2000_0000,  '1,        43'd7,   8'd255, 48'd36,  13'd255};
        vecs[4] = '{'1,             '1,        43'h7FF_FFFF_FFE1, 8'd255,
                    48'd263882790665745, 13'd7650};

        rst = 1'b1; streamEnable = '1; writes = '0; sums = '0; counts = '0;
        eccIn = '0; slowDown = 1'b0;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        checkOutput("resetValid", 64'(resultValid), 64'd0);
        checkOutput("resetSum", 64'(pcoeffSum), 64'd0);
        checkOutput("resetCount", 64'(pcoeffCount), 64'd0);
        checkOutput("resetAllEmpty", 64'(allEmpty), 64'd1);

        // Table vectors: one write per stream, one reduction, fixed latency of 1 + LAT.
        for (int v = 0; v < 5; v++) begin
            streamEnable = vecs[v].en;
            for (int i = 0; i < NS; i++)
                if (vecs[v].wmask[i]) setStream(i, vecs[v].base + SW'(i), vecs[v].cnt);
            start = cycle;
            applyStimulus();
            writes = '0;
            found = 0;
            for (int k = 0; k < 20 && found == 0; k++) begin
                applyStimulus();
                if (resultValid) begin
                    found = cycle - start;
                    gotSum = pcoeffSum;
                    gotCnt = pcoeffCount;
                end
            end
            checkOutput($sformatf("vec%0dLatency", v), 64'(found), 64'(1 + LAT));
            checkOutput($sformatf("vec%0dSum", v), 64'(gotSum), 64'(vecs[v].expSum));
            checkOutput($sformatf("vec%0dCount", v), 64'(gotCnt), 64'(vecs[v].expCnt));
            repeat (2) applyStimulus();
        end

        // Skewed arrival: stream 29 arrives 50 cycles late, single result 59 cycles after start.
        streamEnable = '1;
        seen0 = validSeen;
        for (int i = 0; i < NS - 1; i++) setStream(i, SW'(1000 + i), 8'd1);
        start = cycle;
        applyStimulus();
        writes = '0;
        repeat (49) applyStimulus();
        setStream(NS - 1, SW'(5), 8'd1);
        applyStimulus();
        writes = '0;
        repeat (8) applyStimulus();
        checkOutput("skewResultCount", 64'(validSeen - seen0), 64'd1);
        checkOutput("skewResultCycle", 64'(lastValidAt - start), 64'd59);
        repeat (2) applyStimulus();

        // Fill every FIFO while held off, then overflow stream 3.
        slowDown = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            for (int i = 0; i < NS; i++) begin
                r = {$urandom, $urandom};
                setStream(i, SW'(r), CW'(k));
            end
            applyStimulus();
        end
        writes = '0;
        applyStimulus();
        checkOutput("fillAlmostFull", 64'(almostFull), 64'({NS{1'b1}}));
        setStream(3, SW'(77), 8'd77);
        applyStimulus();
        writes = '0;
        applyStimulus();
        checkOutput("overflowBit3", 64'(overflow), 64'(1) << 3);

        // Drain: 512 back-to-back results with no gaps.
        slowDown = 1'b0;
        seen0 = validSeen;
        firstAt = -1;
        for (int k = 0; k < DEPTH + LAT + 10; k++) begin
            applyStimulus();
            if (resultValid && firstAt < 0) firstAt = cycle;
        end
        checkOutput("drainCount", 64'(validSeen - seen0), 64'(DEPTH));
        checkOutput("drainSpan", 64'(lastValidAt - firstAt), 64'(DEPTH - 1));
        checkOutput("drainAllEmpty", 64'(allEmpty), 64'd1);

        // Reset with five pops in flight: none of them may emerge.
        slowDown = 1'b1;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < NS; i++) setStream(i, SW'(k * 3 + i), CW'(k));
            applyStimulus();
        end
        writes = '0;
        slowDown = 1'b0;
        repeat (5) applyStimulus();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        seen0 = validSeen;
        checkOutput("rstValid", 64'(resultValid), 64'd0);
        checkOutput("rstAllEmpty", 64'(allEmpty), 64'd1);
        repeat (20) applyStimulus();
        checkOutput("rstNoResults", 64'(validSeen - seen0), 64'd0);

        // Randomized traffic: full mask, then a random mask, each ended by a reset.
        for (int round = 0; round < 2; round++) begin
            streamEnable = '1;
            if (round == 1) begin
                streamEnable = NS'($urandom);
                if (streamEnable == '0) streamEnable = NS'(1);
            end
            for (int k = 0; k < 1500; k++) begin
                slowDown = ($urandom_range(0, 3) == 0);
                for (int i = 0; i < NS; i++)
                    if (!almostFull[i] && $urandom_range(0, 3) != 0) begin
                        r = {$urandom, $urandom};
                        setStream(i, SW'(r), CW'(r >> 50));
                    end
                applyStimulus();
                writes = '0;
            end
            rst = 1'b1;
            applyStimulus();
            rst = 1'b0;
            applyStimulus();
        end

        // ECC flag is sticky.
        eccIn = NS'(1) << 7;
        applyStimulus();
        eccIn = '0;
        checkOutput("eccSet", 64'(eccStatus), 64'd1);
        repeat (3) applyStimulus();
        checkOutput("eccSticky", 64'(eccStatus), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
